// File: rtl/fetch_unit_if.sv
// Bundles the fetch front end's ROM port, redirect input and decode handshake.
// The master side belongs to fetch_unit. The slave side belongs to the ROM/control/decode environment.
interface fetch_unit_if #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9
);
    logic [PC_W-1:0]    rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic               redirect_en;
    logic [PC_W-1:0]    redirect_target;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic               done;

    modport master (
        output rom_addr, instr_valid, instr, instr_pc, done,
        input  rom_data, redirect_en, redirect_target, instr_ready
    );

    modport slave (
        input  rom_addr, instr_valid, instr, instr_pc, done,
        output rom_data, redirect_en, redirect_target, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, drives a synchronous ROM and
// buffers returned words in a small shift queue presented over valid/ready.
module fetch_unit #(
    parameter int PC_W      = 10,
    parameter int INSTR_W   = 9,
    parameter int DEPTH     = 2,
    parameter int HALT_ADDR = 128
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);
    localparam int CW = $clog2(DEPTH + 2);
    localparam logic [PC_W-1:0] HaltPc = PC_W'(HALT_ADDR);

    logic [PC_W-1:0]    fetchPc_q, fetchPc_d;
    logic               inflight_q, inflight_d;
    logic [PC_W-1:0]    inflightPc_q, inflightPc_d;
    logic [CW-1:0]      count_q, count_d;
    logic [INSTR_W-1:0] queueData_q [DEPTH];
    logic [INSTR_W-1:0] queueData_d [DEPTH];
    logic [PC_W-1:0]    queuePc_q [DEPTH];
    logic [PC_W-1:0]    queuePc_d [DEPTH];

    logic          pop;
    logic          issue;
    logic          write;
    logic [CW-1:0] occupancy;
    logic [CW-1:0] countAfterPop;

    // Credit check counts the word still in flight so a full queue never drops a ROM return.
    always_comb begin
        fetchPc_d     = fetchPc_q;
        inflight_d    = 1'b0;
        inflightPc_d  = inflightPc_q;
        count_d       = count_q;
        queueData_d   = queueData_q;
        queuePc_d     = queuePc_q;

        pop           = (count_q != '0) && bus.instr_ready;
        occupancy     = count_q + CW'(inflight_q);
        issue         = !bus.redirect_en && (fetchPc_q != HaltPc) &&
                        (occupancy < (CW'(DEPTH) + CW'(pop)));
        write         = inflight_q && !bus.redirect_en;
        countAfterPop = count_q - CW'(pop);

        if (pop && (count_q > CW'(1))) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                queueData_d[i] = queueData_q[i+1];
                queuePc_d[i]   = queuePc_q[i+1];
            end
        end

        if (write) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (countAfterPop == CW'(i)) begin
                    queueData_d[i] = bus.rom_data;
                    queuePc_d[i]   = inflightPc_q;
                end
            end
        end

        // A redirect wins over everything: flush the queue and drop the returning word.
        if (bus.redirect_en) begin
            count_d    = '0;
            inflight_d = 1'b0;
            fetchPc_d  = bus.redirect_target;
        end else begin
            count_d    = countAfterPop + CW'(write);
            inflight_d = issue;
            if (issue) begin
                inflightPc_d = fetchPc_q;
                fetchPc_d    = fetchPc_q + PC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetchPc_q    <= '0;
            inflight_q   <= 1'b0;
            inflightPc_q <= '0;
            count_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                queueData_q[i] <= '0;
                queuePc_q[i]   <= '0;
            end
        end else begin
            fetchPc_q    <= fetchPc_d;
            inflight_q   <= inflight_d;
            inflightPc_q <= inflightPc_d;
            count_q      <= count_d;
            queueData_q  <= queueData_d;
            queuePc_q    <= queuePc_d;
        end
    end

    assign bus.rom_addr    = fetchPc_q;
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr       = queueData_q[0];
    assign bus.instr_pc    = queuePc_q[0];
    assign bus.done        = (fetchPc_q == HaltPc) && (count_q == '0) && !inflight_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal pins plus a
// randomized run compared every cycle against a queue-level behavioural model.
module tb_fetch_unit;
    localparam int PC_W      = 10;
    localparam int INSTR_W   = 9;
    localparam int DEPTH     = 2;
    localparam int HALT_ADDR = 128;

    logic clk = 1'b0;
    logic reset;

    fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    fetch_unit #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .HALT_ADDR(HALT_ADDR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    function automatic logic [INSTR_W-1:0] romWord(input int a);
        return INSTR_W'((a * 7 + 3) % 512);
    endfunction

    always @(posedge clk) bus.rom_data <= romWord(int'(bus.rom_addr));

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Behavioural model: delivered-order queue of pcs, one pending ROM fetch, and the fetch pointer.
    int mq[$];
    int mPending;
    int mFetchPc;
    int mOcc;
    bit mPop;
    bit mIssue;
    bit modelLive = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            mPending  = -1;
            mFetchPc  = 0;
            modelLive = 1'b1;
        end else if (modelLive) begin
            mPop   = (mq.size() > 0) && (bus.instr_ready === 1'b1);
            mOcc   = mq.size() + ((mPending >= 0) ? 1 : 0) - (mPop ? 1 : 0);
            mIssue = !bus.redirect_en && (mFetchPc != HALT_ADDR) && (mOcc < DEPTH);
            if (mPop) void'(mq.pop_front());
            if (bus.redirect_en) begin
                mq.delete();
                mPending = -1;
                mFetchPc = int'(bus.redirect_target);
            end else begin
                if (mPending >= 0) mq.push_back(mPending);
                if (mIssue) begin
                    mPending = mFetchPc;
                    mFetchPc = (mFetchPc + 1) % (1 << PC_W);
                end else begin
                    mPending = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (modelLive) begin
            checkOutput("rom_addr", bus.rom_addr, mFetchPc);
            checkOutput("instr_valid", bus.instr_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                checkOutput("instr_pc", bus.instr_pc, mq[0]);
                checkOutput("instr", bus.instr, romWord(mq[0]));
            end
            checkOutput("done", bus.done,
                        (mFetchPc == HALT_ADDR) && (mq.size() == 0) && (mPending < 0));
        end
    end

    int dutPops[$];

    task automatic applyStimulus(input logic rst, input logic rdy, input logic redir, input int target);
        reset               = rst;
        bus.instr_ready     = rdy;
        bus.redirect_en     = redir;
        bus.redirect_target = PC_W'(target);
        if (!rst && rdy && (bus.instr_valid === 1'b1)) dutPops.push_back(int'(bus.instr_pc));
        @(posedge clk);
        #1;
    endtask

    function automatic int popAt(input int i);
        return (i < dutPops.size()) ? dutPops[i] : -1;
    endfunction

    task automatic runUntilDone(input int budget);
        int n;
        n = 0;
        while ((bus.done !== 1'b1) && (n < budget)) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 0);
            n++;
        end
        checkOutput("halt reached within budget", bus.done, 1);
    endtask

    initial begin
        int r;
        int target;

        // Reset and first fetches
        applyStimulus(1'b1, 1'b1, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 0);
        checkOutput("reset rom_addr", bus.rom_addr, 0);
        checkOutput("reset instr_valid", bus.instr_valid, 0);
        checkOutput("reset done", bus.done, 0);
        checkOutput("reset instr", bus.instr, 0);
        checkOutput("reset instr_pc", bus.instr_pc, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        checkOutput("first cycle valid", bus.instr_valid, 0);
        checkOutput("first cycle rom_addr", bus.rom_addr, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        checkOutput("first head valid", bus.instr_valid, 1);
        checkOutput("first head pc", bus.instr_pc, 0);
        checkOutput("first head instr", bus.instr, 3);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        checkOutput("second head pc", bus.instr_pc, 1);
        checkOutput("second head instr", bus.instr, 10);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        checkOutput("stream head pc3", bus.instr_pc, 3);

        // Backpressure fills the queue
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 0);
        checkOutput("stall head pc", bus.instr_pc, 3);
        checkOutput("stall rom_addr", bus.rom_addr, 5);
        checkOutput("stall valid", bus.instr_valid, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        checkOutput("release head pc4", bus.instr_pc, 4);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        checkOutput("release head pc5", bus.instr_pc, 5);

        // Redirect while pc 5 is being popped
        applyStimulus(1'b0, 1'b1, 1'b1, 40);
        checkOutput("redirect valid +1", bus.instr_valid, 0);
        checkOutput("redirect rom_addr", bus.rom_addr, 40);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        checkOutput("redirect valid +2", bus.instr_valid, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        checkOutput("target head pc", bus.instr_pc, 40);
        checkOutput("target head instr", bus.instr, 283);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        checkOutput("target next pc", bus.instr_pc, 41);
        checkOutput("target next instr", bus.instr, 290);

        // Straight-line run to the halt address
        applyStimulus(1'b1, 1'b1, 1'b0, 0);
        dutPops.delete();
        runUntilDone(400);
        checkOutput("halt last pop", popAt(dutPops.size() - 1), 127);
        checkOutput("halt pop count", dutPops.size(), 128);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 0);
        checkOutput("done holds", bus.done, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 3);
        checkOutput("done drops on redirect", bus.done, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        checkOutput("post-halt head valid", bus.instr_valid, 1);
        checkOutput("post-halt head pc", bus.instr_pc, 3);

        // Full queue, then reset
        applyStimulus(1'b0, 1'b0, 1'b1, 10);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 0);
        checkOutput("full head pc", bus.instr_pc, 10);
        checkOutput("full rom_addr", bus.rom_addr, 12);
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        checkOutput("mid reset valid", bus.instr_valid, 0);
        checkOutput("mid reset done", bus.done, 0);
        checkOutput("mid reset rom_addr", bus.rom_addr, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        checkOutput("after reset valid +1", bus.instr_valid, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        checkOutput("after reset valid +2", bus.instr_valid, 1);
        checkOutput("after reset head pc", bus.instr_pc, 0);

        // PC wrap from the top of the address space
        applyStimulus(1'b0, 1'b1, 1'b1, 1022);
        checkOutput("wrap rom_addr", bus.rom_addr, 1022);
        dutPops.delete();
        runUntilDone(400);
        checkOutput("wrap pop 0", popAt(0), 1022);
        checkOutput("wrap pop 1", popAt(1), 1023);
        checkOutput("wrap pop 2", popAt(2), 0);
        checkOutput("wrap pop 3", popAt(3), 1);
        checkOutput("wrap last pop", popAt(dutPops.size() - 1), 127);
        checkOutput("wrap pop count", dutPops.size(), 130);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            case ($urandom_range(0, 3))
                0:       target = HALT_ADDR - int'($urandom_range(0, 3));
                1:       target = 1020 + int'($urandom_range(0, 3));
                default: target = int'($urandom_range(0, 160));
            endcase
            applyStimulus(r < 1, $urandom_range(0, 99) < 70, (r >= 1) && (r < 7), target);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time expired, required finish before 1000000");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end for the 9-bit single-issue core.
- Owns the fetch program counter, drives the synchronous instruction ROM, and buffers returned words in a small queue.
- Presents instructions to decode/control over a valid/ready handshake.
- Handles taken-jump redirects by flushing stale fetches, and raises done when straight-line fetch reaches the halt address and the pipe has drained.

Parameters:
PC_W, 10, program counter / ROM address width
INSTR_W, 9, machine-code word width
DEPTH, 2, instruction queue entries (≥2)
HALT_ADDR, 128, fetch address at which issue stops and done may assert

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
rom_addr  output  PC_W  address presented to instruction ROM (= fetch_pc)
rom_data  input  INSTR_W  ROM word for the address presented the previous cycle
redirect_en  input  1  taken jump from control; flush and refetch
redirect_target  input  PC_W  new fetch address when redirect_en=1
instr_valid  output  1  queue head valid
instr_ready  input  1  decode accepts head this cycle
instr  output  INSTR_W  queue head machine code
instr_pc  output  PC_W  address of queue head
done  output  1  fetch halted and pipe empty

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset state: fetch_pc=0, inflight=0, count=0, all queue storage cleared. Outputs: rom_addr=0, instr_valid=0, instr=0, instr_pc=0, done=0 (unless HALT_ADDR=0).
- Reset mid-operation discards queue and in-flight fetch. The first cycle after reset issues address 0.
- rom_addr is combinational from the fetch_pc register.
- pop = instr_valid & instr_ready.
- issue = !redirect_en & (fetch_pc != HALT_ADDR) & (count + inflight - pop < DEPTH).
- On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1 modulo 2^PC_W (wraps, no error). Otherwise inflight<=0.
- Return: when inflight=1 and no redirect this cycle, {rom_data, inflight_pc} is written at the queue tail.
  - No combinational bypass: the entry becomes visible the next cycle.
- Latency: an address issued in cycle N is at the head no earlier than cycle N+2.
- Throughput: 1 instr/cycle sustained with instr_ready=1.
- Queue: FIFO order, head drives instr/instr_pc/instr_valid (instr_valid = count>0).
  - Simultaneous write and pop: count unchanged.
  - Full (count=DEPTH) with no pop: no issue, rom_addr holds, no word lost or duplicated.
  - Empty: instr_valid=0; instr/instr_pc hold last head value (don't-care for decode).
- Redirect (highest priority):
  - A pop in the same cycle is still a legal transfer, since the jump itself is consumed.
  - Then: queue cleared (count=0), the in-flight return that cycle is discarded, inflight<=0, fetch_pc<=redirect_target, no issue that cycle.
  - Next cycle issues redirect_target, so the first valid target instr appears 2 cycles after the redirect cycle.
  - redirect_target = HALT_ADDR is legal: fetch halts immediately.
- Halt: fetch stops while fetch_pc==HALT_ADDR. Entries already queued or in flight still drain normally.
  - done = (fetch_pc==HALT_ADDR) & (count==0) & !inflight, decoded from registers (glitch-free, no input path).
  - A redirect while halted leaves halt; done drops the next cycle.
- Back-to-back redirects: the last one wins; every intervening return is discarded.

Test Plan:
1. ROM[i]=i; reset high 2 cycles, then low, instr_ready=1 → instr_valid first high 2 cycles after reset release. instr_pc=0,1,2,... and instr=0,1,2,... on consecutive cycles, no bubbles.
2. Stream with instr_ready=0 for 6 cycles from pc 3 → count saturates at 2, rom_addr holds 5, instr_pc stays 3. On release, pcs 3,4,5,6 delivered in order with no gap or repeat.
3. Redirect pulse with target 40 in the cycle pc 5 is popped → pcs 6/7 never appear. instr_valid=0 for 2 cycles, then instr_pc=40,41,...
4. Straight-line run from 0 with HALT_ADDR=128 → last delivered instr_pc=127. done rises the cycle after pc 127 is popped and stays high; a redirect to 3 drops done and pc 3 is delivered.
5. Full queue, then reset for 1 cycle → next cycle instr_valid=0, done=0, rom_addr=0, and pc 0 is delivered 2 cycles later.
6. Redirect to 1022 with PC_W=10 → delivered pcs 1022,1023,0,1,... (wrap), halting at 128 with done=1.
